// File: rtl/entry_ctrl.sv
// entry_ctrl: push-button front end and mode FSM for a digit-entry block.
//
// Five raw buttons are synchronized, debounced and turned into one-cycle
// press events. U and D also auto-repeat while held. BTNC steps the FSM
// IDLE -> EDIT_A -> EDIT_B -> SHOW -> IDLE; the direction buttons produce
// single-cycle command pulses, but only while editing.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   BTNC/BTNL/BTNR/BTNU/BTND raw asynchronous bouncing push-buttons
//   ctrl[3:0]                registered mode word for the digit-entry block
//   mode[1:0]                FSM state code (0 IDLE, 1 EDIT_A, 2 EDIT_B, 3 SHOW)
//   pL/pR/pU/pD              registered single-cycle command pulses
module entry_ctrl #(
    parameter int DEB_CYCLES = 1000000,
    parameter int RPT_DELAY  = 50000000,
    parameter int RPT_PERIOD = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BTNC,
    input  logic       BTNL,
    input  logic       BTNR,
    input  logic       BTNU,
    input  logic       BTND,
    output logic [3:0] ctrl,
    output logic [1:0] mode,
    output logic       pL,
    output logic       pR,
    output logic       pU,
    output logic       pD
);

    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int RMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST  = RW'(RPT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST  = RW'(RPT_PERIOD - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EDIT_A = 2'd1;
    localparam logic [1:0] S_EDIT_B = 2'd2;
    localparam logic [1:0] S_SHOW   = 2'd3;

    // Button index: 0 C, 1 L, 2 R, 3 U, 4 D.
    logic [4:0] btn_raw;
    assign btn_raw = {BTND, BTNU, BTNR, BTNL, BTNC};

    logic [4:0]    sync1_q, sync2_q;
    logic [4:0]    deb_q, deb_d;
    logic [4:0]    deb_dly_q;
    logic [4:0]    ev_q, ev_d;
    logic [DW-1:0] cnt_q [5];
    logic [DW-1:0] cnt_d [5];

    // Repeat timers, index 0 for U and 1 for D.
    logic [RW-1:0] rcnt_q [2];
    logic [RW-1:0] rcnt_d [2];
    logic [1:0]    rphase_q, rphase_d;   // 0: waiting first delay, 1: periodic
    logic [1:0]    rpt_q, rpt_d;

    logic [1:0] state_q, state_d;
    logic [3:0] ctrl_q, ctrl_d;
    logic       pl_q, pr_q, pu_q, pd_q;
    logic       pl_d, pr_d, pu_d, pd_d;

    logic e_c, e_l, e_r, e_u, e_d;
    logic editing;

    // Debounce counters and press-edge detection.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = cnt_q[i];
            deb_d[i] = deb_q[i];
            if (sync2_q[i] != deb_q[i]) begin
                // The >= compare keeps the counter from ever wrapping.
                if (cnt_q[i] >= DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + DW'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
        // Rising edge of the debounced level only; releases give nothing.
        ev_d = deb_q & ~deb_dly_q;
    end

    // Auto-repeat timers for U and D, restarted at the press edge.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rcnt_d[i]   = rcnt_q[i];
            rphase_d[i] = rphase_q[i];
            rpt_d[i]    = 1'b0;
            if (!deb_q[3+i]) begin
                rcnt_d[i]   = '0;
                rphase_d[i] = 1'b0;
            end else if (!deb_dly_q[3+i]) begin
                // Press cycle: start timing the initial delay.
                rcnt_d[i]   = '0;
                rphase_d[i] = 1'b0;
            end else if (rcnt_q[i] >= (rphase_q[i] ? RP_LAST : RD_LAST)) begin
                rpt_d[i]    = 1'b1;
                rcnt_d[i]   = '0;
                rphase_d[i] = 1'b1;
            end else begin
                rcnt_d[i] = rcnt_q[i] + RW'(1);
            end
        end
    end

    assign e_c = ev_q[0];
    assign e_l = ev_q[1];
    assign e_r = ev_q[2];
    assign e_u = ev_q[3] | rpt_q[0];
    assign e_d = ev_q[4] | rpt_q[1];
    assign editing = (state_q == S_EDIT_A) || (state_q == S_EDIT_B);

    // FSM next state, ctrl word and prioritized direction pulses.
    always_comb begin
        state_d = state_q;
        if (e_c) begin
            case (state_q)
                S_IDLE:   state_d = S_EDIT_A;
                S_EDIT_A: state_d = S_EDIT_B;
                S_EDIT_B: state_d = S_SHOW;
                S_SHOW:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end

        // ctrl follows the next state so it changes on the same edge.
        case (state_d)
            S_IDLE:   ctrl_d = 4'b0000;
            S_EDIT_A: ctrl_d = 4'b0001;
            S_EDIT_B: ctrl_d = 4'b0011;
            S_SHOW:   ctrl_d = 4'b0100;
            default:  ctrl_d = 4'b0000;
        endcase

        pl_d = 1'b0;
        pr_d = 1'b0;
        pu_d = 1'b0;
        pd_d = 1'b0;
        // A centre press in the same cycle swallows every direction event.
        if (editing && !e_c) begin
            if (e_l) begin
                pl_d = 1'b1;
            end else if (e_r) begin
                pr_d = 1'b1;
            end else if (e_u) begin
                pu_d = 1'b1;
            end else if (e_d) begin
                pd_d = 1'b1;
            end else begin
                pl_d = 1'b0;
            end
        end else begin
            pl_d = 1'b0;
        end
    end

    // All state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 5'b00000;
            sync2_q   <= 5'b00000;
            deb_q     <= 5'b00000;
            deb_dly_q <= 5'b00000;
            ev_q      <= 5'b00000;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
            for (int i = 0; i < 2; i++) rcnt_q[i] <= '0;
            rphase_q  <= 2'b00;
            rpt_q     <= 2'b00;
            state_q   <= S_IDLE;
            ctrl_q    <= 4'b0000;
            pl_q      <= 1'b0;
            pr_q      <= 1'b0;
            pu_q      <= 1'b0;
            pd_q      <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            ev_q      <= ev_d;
            for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
            for (int i = 0; i < 2; i++) rcnt_q[i] <= rcnt_d[i];
            rphase_q  <= rphase_d;
            rpt_q     <= rpt_d;
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            pl_q      <= pl_d;
            pr_q      <= pr_d;
            pu_q      <= pu_d;
            pd_q      <= pd_d;
        end
    end

    assign ctrl = ctrl_q;
    assign mode = state_q;
    assign pL   = pl_q;
    assign pR   = pr_q;
    assign pU   = pu_q;
    assign pD   = pd_q;

endmodule

// File: tb/tb_entry_ctrl.sv
// Directed self-checking bench for entry_ctrl with short timing parameters.
module tb_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btnc = 1'b0, btnl = 1'b0, btnr = 1'b0, btnu = 1'b0, btnd = 1'b0;
    logic [3:0] ctrl;
    logic [1:0] mode;
    logic       pl, pr, pu, pd;

    int checks = 0;
    int failures = 0;

    entry_ctrl #(.DEB_CYCLES(4), .RPT_DELAY(20), .RPT_PERIOD(5)) dut (
        .clk(clk), .rst(rst),
        .BTNC(btnc), .BTNL(btnl), .BTNR(btnr), .BTNU(btnu), .BTND(btnd),
        .ctrl(ctrl), .mode(mode),
        .pL(pl), .pR(pr), .pU(pu), .pD(pd)
    );

    always #5 clk = ~clk;

    // One clock; observe 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clean centre press: hold long enough to debounce, then release cleanly.
    task automatic press_c();
        btnc = 1'b1;
        repeat (10) tick();
        btnc = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (ctrl !== 4'b0000 || mode !== 2'd0) begin
            failures++;
            $display("FAIL reset_state ctrl=%b mode=%0d required ctrl=0000 mode=0", ctrl, mode);
        end
        checks++;
        if ({pl, pr, pu, pd} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_pulses got=%b required=0000", {pl, pr, pu, pd});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fsm();
        logic [1:0] exp_mode [4];
        logic [3:0] exp_ctrl [4];
        logic [1:0] prev;
        exp_mode[0] = 2'd1; exp_mode[1] = 2'd2; exp_mode[2] = 2'd3; exp_mode[3] = 2'd0;
        exp_ctrl[0] = 4'b0001; exp_ctrl[1] = 4'b0011; exp_ctrl[2] = 4'b0100; exp_ctrl[3] = 4'b0000;
        prev = 2'd0;
        for (int k = 0; k < 4; k++) begin
            btnc = 1'b1;
            repeat (7) tick();
            checks++;
            if (mode !== prev) begin
                failures++;
                $display("FAIL fsm_early press=%0d mode=%0d required=%0d", k, mode, prev);
            end
            tick();
            checks++;
            if (mode !== exp_mode[k] || ctrl !== exp_ctrl[k]) begin
                failures++;
                $display("FAIL fsm_step press=%0d mode=%0d ctrl=%b required mode=%0d ctrl=%b",
                         k, mode, ctrl, exp_mode[k], exp_ctrl[k]);
            end
            btnc = 1'b0;
            repeat (14) tick();
            checks++;
            if (mode !== exp_mode[k]) begin
                failures++;
                $display("FAIL fsm_hold press=%0d mode=%0d required=%0d", k, mode, exp_mode[k]);
            end
            prev = exp_mode[k];
        end
    endtask

    task automatic test_idle_discard();
        int n = 0;
        btnu = 1'b1;
        for (int t = 0; t < 35; t++) begin
            tick();
            if (pl || pr || pu || pd) n++;
        end
        btnu = 1'b0;
        repeat (12) tick();
        checks++;
        if (n !== 0 || mode !== 2'd0) begin
            failures++;
            $display("FAIL idle_discard pulses=%0d mode=%0d required pulses=0 mode=0", n, mode);
        end
    endtask

    task automatic test_bounce();
        int nl = 0, nother = 0, first = -1;
        for (int i = 0; i < 10; i++) begin
            btnl = ((i / 2) % 2) == 1;
            tick();
            if (pl) nl++;
        end
        btnl = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (pl) begin
                nl++;
                if (first < 0) first = t;
            end
            if (pr || pu || pd) nother++;
        end
        checks++;
        if (nl !== 1) begin
            failures++;
            $display("FAIL bounce_count pL=%0d required=1", nl);
        end
        checks++;
        if (first !== 8) begin
            failures++;
            $display("FAIL bounce_latency observed_tick=%0d required=8", first);
        end
        btnl = 1'b0;
        for (int t = 0; t < 15; t++) begin
            tick();
            if (pl) nl++;
            if (pr || pu || pd) nother++;
        end
        checks++;
        if (nl !== 1 || nother !== 0) begin
            failures++;
            $display("FAIL bounce_release pL=%0d others=%0d required pL=1 others=0", nl, nother);
        end
    endtask

    task automatic test_simultaneous();
        int nl = 0, nd = 0;
        btnl = 1'b1;
        btnd = 1'b1;
        for (int t = 0; t < 15; t++) begin
            tick();
            if (pl) nl++;
            if (pd) nd++;
        end
        btnl = 1'b0;
        btnd = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (pl) nl++;
            if (pd) nd++;
        end
        checks++;
        if (nl !== 1 || nd !== 0) begin
            failures++;
            $display("FAIL prio_l_over_d pL=%0d pD=%0d required pL=1 pD=0", nl, nd);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        btnc = 1'b1;
        btnr = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (pl || pr || pu || pd) n++;
            if (t == 7) begin
                checks++;
                if (mode !== 2'd1) begin
                    failures++;
                    $display("FAIL cr_early mode=%0d required=1", mode);
                end
            end
            if (t == 8) begin
                checks++;
                if (mode !== 2'd2 || ctrl !== 4'b0011) begin
                    failures++;
                    $display("FAIL cr_advance mode=%0d ctrl=%b required mode=2 ctrl=0011", mode, ctrl);
                end
            end
        end
        btnc = 1'b0;
        btnr = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (pl || pr || pu || pd) n++;
        end
        checks++;
        if (n !== 0) begin
            failures++;
            $display("FAIL cr_suppress pulses=%0d required=0", n);
        end
    endtask

    task automatic test_repeat();
        int times [8];
        int n = 0, extra = 0;
        btnu = 1'b1;
        for (int t = 1; t <= 70; t++) begin
            tick();
            if (pu) begin
                if (n < 8) times[n] = t;
                n++;
            end
            if (pl || pr || pd) extra++;
            if (t == 40) btnu = 1'b0;
        end
        checks++;
        if (n !== 5 || extra !== 0) begin
            failures++;
            $display("FAIL repeat_count pU=%0d others=%0d required pU=5 others=0", n, extra);
        end
        checks++;
        if (n >= 5 && (times[0] !== 8 || times[1] !== 28 || times[2] !== 33 ||
                       times[3] !== 38 || times[4] !== 43)) begin
            failures++;
            $display("FAIL repeat_times got=%0d,%0d,%0d,%0d,%0d required=8,28,33,38,43",
                     times[0], times[1], times[2], times[3], times[4]);
        end
    endtask

    task automatic test_reset_repeat();
        int n = 0;
        btnu = 1'b1;
        repeat (30) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({pl, pr, pu, pd} !== 4'b0000 || mode !== 2'd0 || ctrl !== 4'b0000) begin
            failures++;
            $display("FAIL rst_mid_repeat pulses=%b mode=%0d ctrl=%b required 0000/0/0000",
                     {pl, pr, pu, pd}, mode, ctrl);
        end
        tick();
        checks++;
        if (pu !== 1'b0) begin
            failures++;
            $display("FAIL rst_next_cycle pU=%b required=0", pu);
        end
        rst = 1'b0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (pl || pr || pu || pd) n++;
        end
        checks++;
        if (n !== 0 || mode !== 2'd0) begin
            failures++;
            $display("FAIL rst_held_after pulses=%0d mode=%0d required pulses=0 mode=0", n, mode);
        end
        btnu = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_held_reset();
        btnc = 1'b1;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 7) begin
                checks++;
                if (mode !== 2'd0) begin
                    failures++;
                    $display("FAIL held_rst_early mode=%0d required=0", mode);
                end
            end
            if (t == 8) begin
                checks++;
                if (mode !== 2'd1) begin
                    failures++;
                    $display("FAIL held_rst_press mode=%0d required=1", mode);
                end
            end
        end
        btnc = 1'b0;
        repeat (12) tick();
        checks++;
        if (mode !== 2'd1) begin
            failures++;
            $display("FAIL held_rst_single mode=%0d required=1", mode);
        end
    endtask

    initial begin
        test_reset();
        test_fsm();
        test_idle_discard();
        press_c();                // IDLE -> EDIT_A
        test_bounce();
        test_simultaneous();
        test_back_to_back();      // EDIT_A -> EDIT_B
        test_repeat();
        test_reset_repeat();
        test_held_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
